// File: rtl/cic_decimator.sv
// cic_decimator: complex I/Q CIC decimator with shared control and truncated unity-gain output
module cic_decimator #(
    parameter int IN_W       = 17,
    parameter int OUT_W      = 17,
    parameter int STAGES     = 3,
    parameter int DECIM      = 8,
    parameter int DIFF_DELAY = 1
) (
    input  logic                    crystal,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic signed [IN_W-1:0]  in_i,
    input  logic signed [IN_W-1:0]  in_q,
    output logic signed [OUT_W-1:0] out_i,
    output logic signed [OUT_W-1:0] out_q,
    output logic                    out_valid
);
    localparam int W  = IN_W + STAGES * $clog2(DECIM * DIFF_DELAY);
    localparam int CW = $clog2(DECIM);
    localparam int SH = W - OUT_W;

    logic [CW-1:0] cnt;
    logic tick;
    logic signed [IN_W-1:0] x [2];
    logic signed [OUT_W-1:0] y [2];

    assign tick = clk_en && cnt == CW'(DECIM - 1);
    assign x[0] = in_i;
    assign x[1] = in_q;

    always_ff @(posedge crystal) begin
        if (rst) begin
            cnt <= '0;
            out_valid <= 1'b0;
        end else begin
            cnt <= clk_en ? cnt + 1'b1 : cnt;
            out_valid <= tick;
        end
    end

    for (genvar r = 0; r < 2; r++) begin : g_rail
        logic signed [W-1:0] integ [STAGES];
        logic signed [W-1:0] integ_in [STAGES];
        logic signed [W-1:0] comb [STAGES];
        logic signed [W-1:0] stage_in [STAGES];
        logic signed [W-1:0] dly [STAGES][DIFF_DELAY];

        always_comb begin
            integ_in[0] = W'(x[r]);
            stage_in[0] = integ[STAGES-1];
            for (int s = 1; s < STAGES; s++) begin
                integ_in[s] = integ[s-1];
                stage_in[s] = comb[s-1];
            end
        end

        always_ff @(posedge crystal) begin
            if (rst) begin
                for (int s = 0; s < STAGES; s++) begin
                    integ[s] <= '0;
                    comb[s] <= '0;
                    for (int j = 0; j < DIFF_DELAY; j++) dly[s][j] <= '0;
                end
            end else begin
                if (clk_en)
                    for (int s = 0; s < STAGES; s++) integ[s] <= integ[s] + integ_in[s];
                if (tick)
                    for (int s = 0; s < STAGES; s++) begin
                        comb[s] <= stage_in[s] - dly[s][DIFF_DELAY-1];
                        dly[s][0] <= stage_in[s];
                        for (int j = 1; j < DIFF_DELAY; j++) dly[s][j] <= dly[s][j-1];
                    end
            end
        end

        // the last comb register holds its value between ticks, so the output is held too
        assign y[r] = OUT_W'(comb[STAGES-1] >>> SH);
    end

    assign out_i = y[0];
    assign out_q = y[1];
endmodule

// File: doc/cic_decimator.md
# cic_decimator

Complex (I/Q) cascaded integrator-comb decimator directly downstream of the complex mixer. It consumes the mixer's 17-bit signed I/Q products at the crystal rate, decimates by DECIM and emits a registered I/Q output with a one-cycle valid pulse per decimated sample. Both rails share one control path. Unity DC gain comes from truncation of the bit growth.

## Interface
- IN_W, 17: input sample width, signed two's complement (matches the mixer output).
- OUT_W, 17: output sample width, signed.
- STAGES, 3: number of integrator and comb stages (N), 1..6.
- DECIM, 8: decimation ratio R; must be a power of two, 2..64.
- DIFF_DELAY, 1: comb differential delay M, 1 or 2.
- Internal width W = IN_W + STAGES*log2(DECIM*DIFF_DELAY), which is 26 at the defaults.

- crystal  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- clk_en  in  1  input sample strobe; in_i/in_q are consumed only on cycles with clk_en=1.
- in_i  in  IN_W  signed I sample from the mixer.
- in_q  in  IN_W  signed Q sample from the mixer.
- out_i  out  OUT_W  signed decimated I; held between valid pulses.
- out_q  out  OUT_W  signed decimated Q; held between valid pulses.
- out_valid  out  1  one-cycle pulse marking a new out_i/out_q pair.

## Operation
- Reset: every integrator, comb, comb-delay and decimation-counter register is cleared to 0. out_i, out_q and out_valid are also 0. Reset asserted mid-stream discards all history; the first sample after rst deasserts counts as phase 0.
- Integrators, per rail, per cycle with clk_en=1:
  - Sign-extend the input to W.
  - Stage 1 register updates to itself + input.
  - Stage k register updates to itself + the stage k-1 register (pipelined).
  - All arithmetic is modulo 2^W; wrap is intentional and not flagged.
- Decimation counter:
  - Counts 0..DECIM-1 on clk_en and wraps to 0.
  - decim_tick = clk_en AND (counter == DECIM-1).
- Combs, per rail, updated only on decim_tick:
  - The input is the last integrator register's value before this cycle's update.
  - Stage k register updates to its input minus that input delayed by DIFF_DELAY ticks.
  - Stages are pipelined and all update simultaneously; arithmetic is modulo 2^W.
- Output:
  - The cycle after decim_tick, out_i/out_q load the last comb register arithmetic-shifted right by W-OUT_W (truncation toward -inf, no rounding).
  - out_valid is 1 for exactly that cycle and 0 otherwise.
- clk_en=0: all state holds. A gapped input stream yields the same output values as the gapless stream, only spread in time.
- Simultaneous rst and clk_en: rst wins and the sample is dropped.

## Timing
- Throughput: one output per DECIM accepted inputs; no backpressure, and out_valid cannot be stalled.
- Output latency: out_valid rises exactly 1 cycle after the decim_tick cycle.
- Pulse spacing: with clk_en held at 1, pulses are exactly DECIM cycles apart; the first pulse is on cycle DECIM after reset release (cycle 0 is the first accepted sample).
- DC gain: DECIM^STAGES * DIFF_DELAY^STAGES, which truncation cancels exactly. A constant input x settles to output x exactly, with no bias, for positive and negative x.
- Settling: for a step input, out_i/out_q reach the final value by the 8th out_valid pulse at the defaults.
- I and Q rails are cycle-aligned; no skew is permitted between them.

## Test plan
- Reset/idle:
  - Stimulus: assert rst for 3 cycles with clk_en=1 and in_i=in_q=500.
  - Required: out_i=out_q=0 and out_valid=0 throughout.
  - Required after release: first out_valid exactly 8 cycles later.
- DC step:
  - Stimulus: in_i=1000, in_q=-1000, clk_en=1 continuously.
  - Required: from the 8th pulse onward, out_i=1000 and out_q=-1000 exactly.
  - Required: pulses exactly 8 cycles apart.
- Integrator wrap:
  - Stimulus: in_i=65535, in_q=-65536 for 4096 cycles (integrators wrap many times).
  - Required: out_i=65535 and out_q=-65536 on every pulse after settling.
- Gapped strobe:
  - Stimulus: same DC stimulus with clk_en a pseudo-random ~50% pattern.
  - Required: the output value sequence is identical to the gapless run.
  - Required: out_valid pulses only one cycle after a clk_en cycle with counter=7.
- Mid-stream reset:
  - Stimulus: run a sine input, pulse rst for 1 cycle at counter=5.
  - Required: all outputs 0 the next cycle.
  - Required: the following run matches a fresh-from-reset run sample for sample.
- Tone response:
  - Stimulus: in_i = 30000·cos, in_q = 30000·sin at fs/64.
  - Required: output amplitude within 1% of the CIC passband droop model.
  - Required: I/Q phase difference is 90°±0.5°.
